sp_mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one single-port, byte-enabled 32-bit memory (one write port, one combinational read port) between requesters A and B. Each requester issues read or byte-masked write requests over a valid/ready handshake and receives a one-cycle-latency response. The block sits directly in front of the memory and is the only agent driving its write enable, byte enables, addresses and write data.

---
 rtl/sp_mem_arbiter_if.sv | 49 ++++
 rtl/sp_mem_arbiter.sv | 106 ++++++++++
 tb/tb_sp_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_mem_arbiter_if.sv
// Request/response bundle for both requesters plus the memory-side port
// of the arbiter. The arbiter uses the slave view: it receives requests
// and drives the memory. The master view is the requesters and memory.
interface sp_mem_arbiter_if #(
    parameter int LOG_MEM_SIZE = 4
);
    logic                    a_req_valid;
    logic                    a_req_ready;
    logic                    a_req_write;
    logic [3:0]              a_req_byte_en;
    logic [LOG_MEM_SIZE-1:0] a_req_addr;
    logic [31:0]             a_req_wdata;
    logic                    a_rsp_valid;
    logic [31:0]             a_rsp_data;

    logic                    b_req_valid;
    logic                    b_req_ready;
    logic                    b_req_write;
    logic [3:0]              b_req_byte_en;
    logic [LOG_MEM_SIZE-1:0] b_req_addr;
    logic [31:0]             b_req_wdata;
    logic                    b_rsp_valid;
    logic [31:0]             b_rsp_data;

    logic                    mem_write_en;
    logic [3:0]              mem_byte_en;
    logic [LOG_MEM_SIZE-1:0] mem_write_addr;
    logic [LOG_MEM_SIZE-1:0] mem_read_addr;
    logic [31:0]             mem_write_data;
    logic [31:0]             mem_read_data;

    modport slave (
        input  a_req_valid, a_req_write, a_req_byte_en, a_req_addr, a_req_wdata,
        output a_req_ready, a_rsp_valid, a_rsp_data,
        input  b_req_valid, b_req_write, b_req_byte_en, b_req_addr, b_req_wdata,
        output b_req_ready, b_rsp_valid, b_rsp_data,
        output mem_write_en, mem_byte_en, mem_write_addr, mem_read_addr, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output a_req_valid, a_req_write, a_req_byte_en, a_req_addr, a_req_wdata,
        input  a_req_ready, a_rsp_valid, a_rsp_data,
        output b_req_valid, b_req_write, b_req_byte_en, b_req_addr, b_req_wdata,
        input  b_req_ready, b_rsp_valid, b_rsp_data,
        input  mem_write_en, mem_byte_en, mem_write_addr, mem_read_addr, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter: round-robin sharing of one single-port, byte-enabled
// 32-bit memory between requesters A and B. At most one request is
// granted per cycle; its read data (old contents for writes) comes back
// one cycle later as a single-cycle response pulse.
//
// state  | meaning
// PRIO_A | A wins when both requesters are valid
// PRIO_B | B wins when both requesters are valid
module sp_mem_arbiter #(
    parameter int MEM_SIZE     = 16,
    parameter int LOG_MEM_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    sp_mem_arbiter_if.slave    bus
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t prio;
    prio_t prio_next;
    logic  grant_a;
    logic  grant_b;

    // Memory geometry must be a full power-of-two address space
    always_comb begin
        assert (MEM_SIZE == (1 << LOG_MEM_SIZE));
    end

    // Priority pointer register; reset hands the first contention to A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= PRIO_A;
        end else begin
            prio <= prio_next;
        end
    end

    // Grant decision and pointer update; nothing is granted while in reset
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        prio_next = prio;
        if (!rst) begin
            if (bus.a_req_valid && (!bus.b_req_valid || prio == PRIO_A)) begin
                grant_a = 1'b1;
            end else if (bus.b_req_valid) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            prio_next = PRIO_B;
        end else if (grant_b) begin
            prio_next = PRIO_A;
        end
    end

    assign bus.a_req_ready = grant_a;
    assign bus.b_req_ready = grant_b;

    // Route the granted request onto the memory port; idle port is all zero
    always_comb begin
        bus.mem_write_en   = 1'b0;
        bus.mem_byte_en    = 4'b0000;
        bus.mem_write_addr = '0;
        bus.mem_read_addr  = '0;
        bus.mem_write_data = 32'h0;
        if (grant_a) begin
            bus.mem_write_en   = bus.a_req_write;
            bus.mem_byte_en    = bus.a_req_byte_en;
            bus.mem_write_addr = bus.a_req_addr;
            bus.mem_read_addr  = bus.a_req_addr;
            bus.mem_write_data = bus.a_req_wdata;
        end else if (grant_b) begin
            bus.mem_write_en   = bus.b_req_write;
            bus.mem_byte_en    = bus.b_req_byte_en;
            bus.mem_write_addr = bus.b_req_addr;
            bus.mem_read_addr  = bus.b_req_addr;
            bus.mem_write_data = bus.b_req_wdata;
        end
    end

    // Capture the pre-edge read data for the granted requester; the other
    // requester's data register holds its last response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.a_rsp_valid <= 1'b0;
            bus.a_rsp_data  <= 32'h0;
            bus.b_rsp_valid <= 1'b0;
            bus.b_rsp_data  <= 32'h0;
        end else begin
            bus.a_rsp_valid <= grant_a;
            bus.b_rsp_valid <= grant_b;
            if (grant_a) begin
                bus.a_rsp_data <= bus.mem_read_data;
            end
            if (grant_b) begin
                bus.b_rsp_data <= bus.mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: hosts a byte-enabled memory, runs a directed
// vector table, a mid-operation reset sequence and a randomized phase
// checked against a behavioural model of the arbitration rules.
module tb_sp_mem_arbiter;

    localparam int AW = 4;
    localparam int NW = 16;

    typedef struct packed {
        logic          valid;
        logic          write;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    typedef struct {
        req_t        ra;
        req_t        rb;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic        exp_we;
        logic        exp_a_rv;
        logic [31:0] exp_a_rd;
        logic        exp_b_rv;
        logic [31:0] exp_b_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] tb_mem  [NW];
    logic [31:0] ref_mem [NW];

    // model state: next contention winner (0 = A), expected response registers
    logic        turn;
    logic        exp_a_rv, exp_b_rv;
    logic [31:0] exp_a_rd, exp_b_rd;

    logic act_a_ready, act_b_ready, act_we;

    sp_mem_arbiter_if #(.LOG_MEM_SIZE(AW)) bus ();

    sp_mem_arbiter #(.MEM_SIZE(NW), .LOG_MEM_SIZE(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h11223344;
        if (i == 7) return 32'h12345678;
        return 32'hC0DE0000 | i;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic req_t mk(input logic v, input logic w, input logic [3:0] be,
                                input int addr, input logic [31:0] wd);
        req_t r;
        r.valid = v;
        r.write = w;
        r.be    = be;
        r.addr  = addr[AW-1:0];
        r.wdata = wd;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.valid = ($urandom_range(0, 9) < 6);
        r.write = 1'($urandom_range(0, 1));
        r.be    = 4'($urandom_range(0, 15));
        r.addr  = AW'($urandom_range(0, NW - 1));
        r.wdata = $urandom;
        return r;
    endfunction

    // the memory the arbiter fronts
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) tb_mem[i] <= init_word(i);
        end else if (bus.mem_write_en) begin
            tb_mem[bus.mem_write_addr] <= merge(tb_mem[bus.mem_write_addr],
                                                bus.mem_write_data, bus.mem_byte_en);
        end
    end

    assign bus.mem_read_data = tb_mem[bus.mem_read_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic set_inputs(input req_t ra, input req_t rb);
        bus.a_req_valid   = ra.valid;
        bus.a_req_write   = ra.write;
        bus.a_req_byte_en = ra.be;
        bus.a_req_addr    = ra.addr;
        bus.a_req_wdata   = ra.wdata;
        bus.b_req_valid   = rb.valid;
        bus.b_req_write   = rb.write;
        bus.b_req_byte_en = rb.be;
        bus.b_req_addr    = rb.addr;
        bus.b_req_wdata   = rb.wdata;
    endtask

    // one cycle: apply requests, check grant/memory port, then the responses
    task automatic drive(input req_t ra, input req_t rb);
        logic          ga, gb, we;
        logic [3:0]    be;
        logic [AW-1:0] ad;
        logic [31:0]   wd;
        @(negedge clk);
        set_inputs(ra, rb);
        #1;
        act_a_ready = bus.a_req_ready;
        act_b_ready = bus.b_req_ready;
        act_we      = bus.mem_write_en;
        ga = !rst && ra.valid && (!rb.valid || turn == 1'b0);
        gb = !rst && rb.valid && !ga;
        chk("a_req_ready", bus.a_req_ready, ga);
        chk("b_req_ready", bus.b_req_ready, gb);
        we = 1'b0; be = 4'h0; ad = '0; wd = 32'h0;
        if (ga) begin
            we = ra.write; be = ra.be; ad = ra.addr; wd = ra.wdata;
        end else if (gb) begin
            we = rb.write; be = rb.be; ad = rb.addr; wd = rb.wdata;
        end
        chk("mem_write_en",   bus.mem_write_en,   we);
        chk("mem_byte_en",    bus.mem_byte_en,    be);
        chk("mem_write_addr", bus.mem_write_addr, ad);
        chk("mem_read_addr",  bus.mem_read_addr,  ad);
        chk("mem_write_data", bus.mem_write_data, wd);
        if (rst) begin
            exp_a_rv = 1'b0; exp_b_rv = 1'b0;
            exp_a_rd = 32'h0; exp_b_rd = 32'h0;
            turn = 1'b0;
        end else begin
            exp_a_rv = ga;
            exp_b_rv = gb;
            if (ga) begin
                exp_a_rd = ref_mem[ra.addr];
                if (ra.write) ref_mem[ra.addr] = merge(ref_mem[ra.addr], ra.wdata, ra.be);
                turn = 1'b1;
            end
            if (gb) begin
                exp_b_rd = ref_mem[rb.addr];
                if (rb.write) ref_mem[rb.addr] = merge(ref_mem[rb.addr], rb.wdata, rb.be);
                turn = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("a_rsp_valid", bus.a_rsp_valid, exp_a_rv);
        chk("a_rsp_data",  bus.a_rsp_data,  exp_a_rd);
        chk("b_rsp_valid", bus.b_rsp_valid, exp_b_rv);
        chk("b_rsp_data",  bus.b_rsp_data,  exp_b_rd);
    endtask

    vec_t tbl [14];

    initial begin
        req_t idle, pa, pb;
        idle = mk(0, 0, 4'h0, 0, 32'h0);

        tbl[0]  = '{mk(1, 1, 4'hF, 3, 32'hDEADBEEF), idle, 1, 0, 1, 1, 32'hC0DE0003, 0, 32'h0};
        tbl[1]  = '{mk(1, 0, 4'h0, 3, 32'h0), idle,          1, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0};
        tbl[2]  = '{mk(1, 0, 4'h0, 1, 32'h0), mk(1, 0, 4'h0, 2, 32'h0),
                    0, 1, 0, 0, 32'hDEADBEEF, 1, 32'hC0DE0002};
        tbl[3]  = '{mk(1, 0, 4'h0, 1, 32'h0), mk(1, 0, 4'h0, 2, 32'h0),
                    1, 0, 0, 1, 32'hC0DE0001, 0, 32'hC0DE0002};
        tbl[4]  = '{mk(1, 0, 4'h0, 1, 32'h0), mk(1, 0, 4'h0, 2, 32'h0),
                    0, 1, 0, 0, 32'hC0DE0001, 1, 32'hC0DE0002};
        tbl[5]  = '{mk(1, 0, 4'h0, 1, 32'h0), mk(1, 0, 4'h0, 2, 32'h0),
                    1, 0, 0, 1, 32'hC0DE0001, 0, 32'hC0DE0002};
        tbl[6]  = '{idle, mk(1, 1, 4'b0101, 5, 32'hAABBCCDD),
                    0, 1, 1, 0, 32'hC0DE0001, 1, 32'h11223344};
        tbl[7]  = '{idle, mk(1, 0, 4'h0, 5, 32'h0),  0, 1, 0, 0, 32'hC0DE0001, 1, 32'h11BB33DD};
        tbl[8]  = '{mk(1, 1, 4'b0000, 7, 32'hFFFFFFFF), idle,
                    1, 0, 1, 1, 32'h12345678, 0, 32'h11BB33DD};
        tbl[9]  = '{mk(1, 0, 4'h0, 7, 32'h0), idle,  1, 0, 0, 1, 32'h12345678, 0, 32'h11BB33DD};
        tbl[10] = '{idle, mk(1, 0, 4'h0, 0, 32'h0),  0, 1, 0, 0, 32'h12345678, 1, 32'hC0DE0000};
        tbl[11] = '{idle, mk(1, 0, 4'h0, 1, 32'h0),  0, 1, 0, 0, 32'h12345678, 1, 32'hC0DE0001};
        tbl[12] = '{idle, mk(1, 0, 4'h0, 2, 32'h0),  0, 1, 0, 0, 32'h12345678, 1, 32'hC0DE0002};
        tbl[13] = '{idle, idle,                      0, 0, 0, 0, 32'h12345678, 0, 32'hC0DE0002};

        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        turn = 1'b0;
        exp_a_rv = 1'b0; exp_b_rv = 1'b0;
        exp_a_rd = 32'h0; exp_b_rd = 32'h0;

        // reset with both requesters asserting: nothing may be granted
        rst = 1'b1;
        preload = 1'b1;
        set_inputs(mk(1, 1, 4'hF, 1, 32'hFFFFFFFF), mk(1, 1, 4'hF, 2, 32'hFFFFFFFF));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_rsp_valid", bus.a_rsp_valid, 0);
        chk("rst_a_rsp_data",  bus.a_rsp_data,  0);
        chk("rst_b_rsp_valid", bus.b_rsp_valid, 0);
        chk("rst_b_rsp_data",  bus.b_rsp_data,  0);
        chk("rst_a_req_ready", bus.a_req_ready, 0);
        chk("rst_b_req_ready", bus.b_req_ready, 0);
        chk("rst_mem_write_en", bus.mem_write_en, 0);
        chk("rst_mem_byte_en", bus.mem_byte_en, 0);
        @(negedge clk);
        set_inputs(idle, idle);
        preload = 1'b0;
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ra, tbl[i].rb);
            chk($sformatf("v%0d_a_ready", i),    act_a_ready,     tbl[i].exp_a_ready);
            chk($sformatf("v%0d_b_ready", i),    act_b_ready,     tbl[i].exp_b_ready);
            chk($sformatf("v%0d_we", i),         act_we,          tbl[i].exp_we);
            chk($sformatf("v%0d_a_rsp_valid", i), bus.a_rsp_valid, tbl[i].exp_a_rv);
            chk($sformatf("v%0d_a_rsp_data", i), bus.a_rsp_data,  tbl[i].exp_a_rd);
            chk($sformatf("v%0d_b_rsp_valid", i), bus.b_rsp_valid, tbl[i].exp_b_rv);
            chk($sformatf("v%0d_b_rsp_data", i), bus.b_rsp_data,  tbl[i].exp_b_rd);
        end

        // reset right after a grant: response pulse must vanish at once
        drive(mk(1, 0, 4'h0, 4, 32'h0), idle);
        chk("pre_rst_a_rsp_valid", bus.a_rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_drop_a_rsp_valid", bus.a_rsp_valid, 0);
        chk("rst_drop_a_rsp_data",  bus.a_rsp_data,  0);
        exp_a_rv = 1'b0; exp_b_rv = 1'b0;
        exp_a_rd = 32'h0; exp_b_rd = 32'h0;
        turn = 1'b0;
        repeat (2) begin
            drive(mk(1, 1, 4'hF, 4, 32'h11111111), mk(1, 1, 4'hF, 6, 32'h22222222));
            chk("rst_hold_mem_write_en", act_we, 0);
        end
        #2 rst = 1'b0;
        drive(mk(1, 0, 4'h0, 4, 32'h0), mk(1, 0, 4'h0, 6, 32'h0));
        chk("post_rst_a_first", act_a_ready, 1);
        chk("post_rst_a_data",  bus.a_rsp_data, 32'hC0DE0004);
        drive(mk(1, 0, 4'h0, 4, 32'h0), mk(1, 0, 4'h0, 6, 32'h0));
        chk("post_rst_b_second", act_b_ready, 1);
        chk("post_rst_b_data",   bus.b_rsp_data, 32'hC0DE0006);

        // randomized traffic; a request is held until accepted
        pa = idle;
        pb = idle;
        for (int c = 0; c < 400; c++) begin
            if (!pa.valid) pa = rnd_req();
            if (!pb.valid) pb = rnd_req();
            drive(pa, pb);
            if (act_a_ready) pa.valid = 1'b0;
            if (act_b_ready) pb.valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
